// File: rtl/ram_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ram_fifo_pkg
// Purpose : Definitions shared by the ram_fifo packet FIFO blocks. It holds
//           the write-side packet state encoding and the pointer-width helper
//           that both ram_fifo and ram_fifo_wr_ctrl use to size their
//           wrap-bit pointers.
// Contents: wr_state_e   write controller packet state
//           fifo_ptr_w() pointer width (address bits + wrap bit)
// Revision: 1.0  initial release
// ============================================================================
package ram_fifo_pkg;

  // Write-side packet state.
  //   IDLE : no beat of the current packet accepted yet (pend is always 0)
  //   PKT  : packet in progress, beats written at the private write pointer
  //   DROP : tail of an oversized packet, beats accepted and discarded
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT  = 2'd1,
    DROP = 2'd2
  } wr_state_e;

  // Pointer width for a FIFO of 'depth' entries: the address bits plus one
  // extra wrap bit, so that full (difference == depth) and empty
  // (difference == 0) can be told apart.
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : ram_fifo_pkg
`default_nettype wire

// File: rtl/ram_fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ram_fifo_wr_ctrl
// Purpose : Write-side packet controller for ram_fifo. Beats of a packetised
//           stream are written into the FIFO RAM at a private write pointer
//           (waddr). The commit pointer seen by the read side (xaddr) only
//           advances when a packet ends cleanly; errored or oversized packets
//           rewind waddr to the last commit point, so the reader only ever
//           sees whole good packets.
// Ports   : clk, rst          clock, asynchronous active-high reset
//           s_data/s_valid/s_ready/s_last/s_err
//                             packet stream in (s_err sampled on last beat)
//           waddr, wdata, wen RAM write port to ram_fifo (waddr has wrap bit)
//           xaddr             commit pointer to ram_fifo
//           fifo_count        committed occupancy from ram_fifo
//           pkt_cnt, drop_cnt committed / dropped packet counters (wrap)
// Revision: 1.0  initial release
// ============================================================================
module ram_fifo_wr_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 16,
  parameter int CNT_WIDTH    = 16,
  localparam int ADDR_WIDTH  = $clog2(DEPTH),
  localparam int PTR_W       = fifo_ptr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_last,
  input  logic                  s_err,
  output logic [PTR_W-1:0]      waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wen,
  output logic [PTR_W-1:0]      xaddr,
  input  logic [PTR_W-1:0]      fifo_count,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);

  // DEPTH is a power of two, so as a wrap-bit pointer difference it is the
  // wrap bit alone.
  localparam logic [PTR_W-1:0] DEPTH_P = {1'b1, {ADDR_WIDTH{1'b0}}};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  wr_state_e              state_q,    state_d;
  logic [PTR_W-1:0]       waddr_q,    waddr_d;
  logic [PTR_W-1:0]       xaddr_q,    xaddr_d;
  logic [CNT_WIDTH-1:0]   pkt_cnt_q,  pkt_cnt_d;
  logic [CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;

  // --------------------------------------------------------------------------
  // Occupancy
  // --------------------------------------------------------------------------
  logic [PTR_W-1:0] pend;       // written but not yet committed beats
  logic [PTR_W-1:0] used;       // pend + committed beats still unread
  logic             space;
  logic             pend_full;  // current packet alone fills the RAM
  logic             in_drop;
  logic             accept;
  logic             overflow;
  logic [PTR_W-1:0] waddr_inc;

  // All pointer arithmetic is modulo 2^PTR_W; the wrap bit makes the
  // differences unambiguous between 0 and DEPTH.
  assign pend      = waddr_q - xaddr_q;
  assign used      = pend + fifo_count;
  assign space     = (used != DEPTH_P);
  assign pend_full = (pend == DEPTH_P);
  assign in_drop   = (state_q == DROP);
  assign waddr_inc = waddr_q + PTR_W'(1);

  // With pend == DEPTH the RAM holds nothing but the current packet, which
  // cannot fit. Keep accepting so the packet is rolled back and drained
  // instead of stalling forever waiting for space that never comes.
  assign s_ready  = in_drop | space | pend_full;
  assign accept   = s_valid & s_ready;
  assign overflow = accept & pend_full & ~in_drop;

  // Combinational write port: a beat is written in the cycle it is accepted.
  assign wen   = accept & ~in_drop & ~overflow;
  assign wdata = s_data;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    waddr_d    = waddr_q;
    xaddr_d    = xaddr_q;
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;

    if (accept) begin
      case (state_q)
        DROP: begin
          // Discard the tail; the drop was already counted at rollback and
          // s_err no longer matters.
          if (s_last) begin
            state_d = IDLE;
          end
        end

        default: begin  // IDLE, PKT
          if (overflow) begin
            // Packet longer than the RAM: rewind and drain the remainder.
            waddr_d    = xaddr_q;
            drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
            state_d    = s_last ? IDLE : DROP;
          end else if (s_last) begin
            if (s_err) begin
              // The errored last beat was written, but rewinding waddr
              // makes that write invisible and reusable.
              waddr_d    = xaddr_q;
              drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
            end else begin
              // Publish the packet; its last beat lands in RAM on the same
              // edge that moves xaddr, so the reader never sees it early.
              waddr_d   = waddr_inc;
              xaddr_d   = waddr_inc;
              pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
            end
            state_d = IDLE;
          end else begin
            waddr_d = waddr_inc;
            state_d = PKT;
          end
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      waddr_q    <= '0;
      xaddr_q    <= '0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      waddr_q    <= waddr_d;
      xaddr_q    <= xaddr_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign waddr    = waddr_q;
  assign xaddr    = xaddr_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;

endmodule : ram_fifo_wr_ctrl
`default_nettype wire
